// File: rtl/lfsr32_hex_source.sv
// 32-bit Galois LFSR source for eight hex digit decoders: free-run, single-step and seed load.
// Optional period detector enabled by defining LFSR32_PERIOD_DETECT_EN.
module lfsr32_hex_source #(
  parameter logic [31:0] TICK_DIV = 32'd50_000_000,
  parameter logic [31:0] SEED     = 32'h0000_0001,
  parameter logic [31:0] TAPS     = 32'h8020_0003
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step_req,
  input  logic        load,
  input  logic [31:0] seed_in,
  output logic [31:0] lfsr_q,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic [3:0]  digit5,
  output logic [3:0]  digit6,
  output logic [3:0]  digit7,
  output logic        shift_strobe,
  output logic        zero_seed,
  output logic        period_hit
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [31:0] TICK_LAST = TICK_DIV - 32'd1;

  function automatic logic [31:0] galois_next(input logic [31:0] q);
    galois_next = q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] lfsr_state_q, lfsr_state_d;
  logic [31:0] presc_q, presc_d;
  logic        strobe_q, strobe_d;
  logic        zero_q, zero_d;
  logic        sync1_q, sync2_q, edge_q;
  logic        rel_q, armed_q;
  logic        step_pulse_s, tick_s, do_shift_s;
  logic [31:0] shift_next_s, load_val_s;

  // A request held high across reset release must fall before it can arm a step.
  assign step_pulse_s = armed_q & sync2_q & ~edge_q;
  assign tick_s       = (state_q == ST_RUN) && (presc_q == TICK_LAST);
  assign shift_next_s = galois_next(lfsr_state_q);
  assign load_val_s   = (seed_in == 32'h0000_0000) ? SEED : seed_in;

  // step_req synchronizer, edge-detect history and post-reset arming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      rel_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= step_req;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      rel_q   <= 1'b1;
      armed_q <= armed_q | (rel_q & ~sync1_q);
    end
  end

  // Next-state, prescaler and shift/load decision
  always_comb begin
    state_d    = state_q;
    presc_d    = 32'h0000_0000;
    do_shift_s = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (step_pulse_s) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RUN: begin
        do_shift_s = tick_s;
        presc_d    = tick_s ? 32'h0000_0000 : presc_q + 32'd1;
        state_d    = run ? ST_RUN : ST_HOLD;
      end
      ST_STEP: begin
        do_shift_s = 1'b1;
        state_d    = ST_HOLD;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase

    if (load) begin
      do_shift_s = 1'b0;
      presc_d    = 32'h0000_0000;
      if (state_d == ST_STEP) begin
        state_d = ST_HOLD;
      end else begin
        state_d = state_d;
      end
    end else begin
      presc_d = presc_d;
    end

    if (load) begin
      lfsr_state_d = load_val_s;
      zero_d       = (seed_in == 32'h0000_0000);
    end else if (do_shift_s) begin
      lfsr_state_d = shift_next_s;
      zero_d       = zero_q;
    end else begin
      lfsr_state_d = lfsr_state_q;
      zero_d       = zero_q;
    end
    strobe_d = load | do_shift_s;
  end

  // Main state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HOLD;
      lfsr_state_q <= SEED;
      presc_q      <= 32'h0000_0000;
      strobe_q     <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_state_q <= lfsr_state_d;
      presc_q      <= presc_d;
      strobe_q     <= strobe_d;
      zero_q       <= zero_d;
    end
  end

`ifdef LFSR32_PERIOD_DETECT_EN
  logic [31:0] ref_q;
  logic [31:0] shift_cnt_q;
  logic        hit_q;

  // Reference value, saturating shift count and return-to-reference pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q       <= SEED;
      shift_cnt_q <= 32'h0000_0000;
      hit_q       <= 1'b0;
    end else if (load) begin
      ref_q       <= load_val_s;
      shift_cnt_q <= 32'h0000_0000;
      hit_q       <= 1'b0;
    end else if (do_shift_s) begin
      shift_cnt_q <= (shift_cnt_q == 32'hFFFF_FFFF) ? shift_cnt_q : shift_cnt_q + 32'd1;
      hit_q       <= (shift_next_s == ref_q) && (shift_cnt_q != 32'hFFFF_FFFF);
    end else begin
      hit_q       <= 1'b0;
    end
  end

  assign period_hit = hit_q;
`else
  assign period_hit = 1'b0;
`endif

  assign lfsr_q       = lfsr_state_q;
  assign shift_strobe = strobe_q;
  assign zero_seed    = zero_q;
  assign digit0 = lfsr_state_q[3:0];
  assign digit1 = lfsr_state_q[7:4];
  assign digit2 = lfsr_state_q[11:8];
  assign digit3 = lfsr_state_q[15:12];
  assign digit4 = lfsr_state_q[19:16];
  assign digit5 = lfsr_state_q[23:20];
  assign digit6 = lfsr_state_q[27:24];
  assign digit7 = lfsr_state_q[31:28];

endmodule

// File: tb/tb_lfsr32_hex_source.sv
// Scoreboard bench for lfsr32_hex_source: stimulus pushes expected states, a monitor pops on shift_strobe.
// Also exercises the LFSR32_PERIOD_DETECT_EN build with a 4-bit maximal mask when that macro is defined.
module tb_lfsr32_hex_source;

  logic        clk = 1'b0;
  logic        rst_n, run, step_req, load;
  logic [31:0] seed_in;
  logic [31:0] lfsr_q;
  logic [3:0]  digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7;
  logic        shift_strobe, zero_seed, period_hit;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_strobe = 0;
  int          cyc = 0;
  int          hit_seen = 0;
  logic [31:0] exp_q[$];
  int          stamp_q[$];
  int          rise_q[$];
  logic [31:0] digits_s;

  assign digits_s = {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};

  lfsr32_hex_source #(.TICK_DIV(32'd4), .SEED(32'h0000_0001), .TAPS(32'h8020_0003)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req), .load(load), .seed_in(seed_in),
    .lfsr_q(lfsr_q), .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .digit4(digit4), .digit5(digit5), .digit6(digit6), .digit7(digit7),
    .shift_strobe(shift_strobe), .zero_seed(zero_seed), .period_hit(period_hit)
  );

`ifdef LFSR32_PERIOD_DETECT_EN
  logic        per_run = 1'b1;
  logic        per_step = 1'b0;
  logic        per_load = 1'b0;
  logic [31:0] per_seed = 32'h0000_0000;
  logic [31:0] per_q;
  logic [3:0]  pd0, pd1, pd2, pd3, pd4, pd5, pd6, pd7;
  logic        per_strobe, per_zero, per_hit;
  int          per_cnt = 0;
  int          per_first = 0;

  lfsr32_hex_source #(.TICK_DIV(32'd2), .SEED(32'h0000_0001), .TAPS(32'h0000_000C)) dut_per (
    .clk(clk), .rst_n(rst_n), .run(per_run), .step_req(per_step), .load(per_load), .seed_in(per_seed),
    .lfsr_q(per_q), .digit0(pd0), .digit1(pd1), .digit2(pd2), .digit3(pd3),
    .digit4(pd4), .digit5(pd5), .digit6(pd6), .digit7(pd7),
    .shift_strobe(per_strobe), .zero_seed(per_zero), .period_hit(per_hit)
  );

  always @(negedge clk) begin
    if (rst_n && per_strobe) begin
      per_cnt = per_cnt + 1;
      if (per_hit && per_first == 0) per_first = per_cnt;
    end
  end
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && period_hit) hit_seen = hit_seen + 1;
    if (rst_n && shift_strobe) begin
      n_strobe = n_strobe + 1;
      stamp_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp  = n_cmp + 1;
        n_fail = n_fail + 1;
        $display("FAIL unexpected_strobe: got lfsr %h, expected no strobe", lfsr_q);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("strobe_lfsr", lfsr_q, e);
        check("strobe_digits", digits_s, e);
      end
    end
  end

  logic [31:0] step_vec [3] = '{32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
  int          r;
  int          lat;

  initial begin
    rst_n = 1'b0; run = 1'b0; step_req = 1'b0; load = 1'b0; seed_in = 32'h0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, idle
    repeat (100) @(negedge clk);
    check("reset_lfsr", lfsr_q, 32'h0000_0001);
    check("reset_digits", digits_s, 32'h0000_0001);
    check("reset_zero_seed", {31'd0, zero_seed}, 32'd0);
    check("reset_strobes", n_strobe, 32'd0);

    // Single steps
    stamp_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(step_vec[i]);
      rise_q.push_back(cyc);
      step_req = 1'b1;
      repeat (4) @(negedge clk);
      step_req = 1'b0;
      repeat (10) @(negedge clk);
    end
    check("step_final", lfsr_q, 32'h6018_0001);
    check("step_count", stamp_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < stamp_q.size(); i++) begin
      lat = stamp_q[i] - rise_q[i];
      check("step_latency_ok", {31'd0, (lat >= 3 && lat <= 5)}, 32'd1);
    end

    // Reset with step_req held high: no step until it falls and rises
    step_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = n_strobe;
    repeat (12) @(negedge clk);
    check("held_step_lfsr", lfsr_q, 32'h0000_0001);
    check("held_step_strobes", n_strobe - r, 32'd0);
    step_req = 1'b0;
    repeat (5) @(negedge clk);
    exp_q.push_back(32'h8020_0003);
    step_req = 1'b1;
    repeat (4) @(negedge clk);
    step_req = 1'b0;
    repeat (6) @(negedge clk);
    check("rearm_step_lfsr", lfsr_q, 32'h8020_0003);

    // Free-run from SEED with TICK_DIV=4
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    stamp_q.delete();
    exp_q.push_back(32'h8020_0003);
    exp_q.push_back(32'hC030_0002);
    exp_q.push_back(32'h6018_0001);
    r = cyc;
    run = 1'b1;
    repeat (13) @(negedge clk);
    run = 1'b0;
    repeat (20) @(negedge clk);
    check("run_hold_lfsr", lfsr_q, 32'h6018_0001);
    check("run_count", stamp_q.size(), 32'd3);
    if (stamp_q.size() == 3) begin
      check("run_first_ok", {31'd0, (stamp_q[0] - r >= 4 && stamp_q[0] - r <= 5)}, 32'd1);
      check("run_gap1", stamp_q[1] - stamp_q[0], 32'd4);
      check("run_gap2", stamp_q[2] - stamp_q[1], 32'd4);
    end

    // Zero-seed load falls back to SEED, then a real seed
    exp_q.push_back(32'h0000_0001);
    load = 1'b1; seed_in = 32'h0000_0000;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("zero_load_lfsr", lfsr_q, 32'h0000_0001);
    check("zero_seed_set", {31'd0, zero_seed}, 32'd1);
    exp_q.push_back(32'hDEAD_BEEF);
    load = 1'b1; seed_in = 32'hDEAD_BEEF;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("zero_seed_clear", {31'd0, zero_seed}, 32'd0);
    check("digit7_D", {28'd0, digit7}, 32'hD);
    check("digit0_F", {28'd0, digit0}, 32'hF);

    // Load coincident with a tick: load wins, next shift TICK_DIV later
    stamp_q.delete();
    run = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h091A_2B3C);
    load = 1'b1; seed_in = 32'h1234_5678;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    run = 1'b0;
    repeat (10) @(negedge clk);
    check("load_tick_lfsr", lfsr_q, 32'h091A_2B3C);
    check("load_tick_count", stamp_q.size(), 32'd2);
    if (stamp_q.size() == 2) check("load_tick_gap", stamp_q[1] - stamp_q[0], 32'd4);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("main_period_hit", hit_seen, 32'd0);
`ifdef LFSR32_PERIOD_DETECT_EN
    check("period_first_hit", per_first, 32'd15);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
